// File: rtl/vga_timing_gen_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : vga_timing_gen_if                                             |
// | Purpose  : Pixel-request / pixel-data / VGA pin bundle of vga_timing_gen.|
// |            master = timing generator, slave = pixel source / pin side.   |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
interface vga_timing_gen_if #(
  parameter int COLOR_W = 1
);
  logic [1:0]         mode_i;
  logic [COLOR_W-1:0] pix_r_i;
  logic [COLOR_W-1:0] pix_g_i;
  logic [COLOR_W-1:0] pix_b_i;
  logic [11:0]        pix_x_o;
  logic [10:0]        pix_y_o;
  logic               pix_act_o;
  logic               vga_hs_o;
  logic               vga_vs_o;
  logic               vga_de_o;
  logic [COLOR_W-1:0] vga_r_o;
  logic [COLOR_W-1:0] vga_g_o;
  logic [COLOR_W-1:0] vga_b_o;
  logic               frame_start_o;
  logic               line_start_o;

  modport master (
    input  mode_i, pix_r_i, pix_g_i, pix_b_i,
    output pix_x_o, pix_y_o, pix_act_o,
    output vga_hs_o, vga_vs_o, vga_de_o, vga_r_o, vga_g_o, vga_b_o,
    output frame_start_o, line_start_o
  );

  modport slave (
    output mode_i, pix_r_i, pix_g_i, pix_b_i,
    input  pix_x_o, pix_y_o, pix_act_o,
    input  vga_hs_o, vga_vs_o, vga_de_o, vga_r_o, vga_g_o, vga_b_o,
    input  frame_start_o, line_start_o
  );
endinterface
`default_nettype wire

// File: rtl/vga_timing_gen.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : vga_timing_gen                                                |
// | Purpose  : Parametrised VGA timing generator with registered HS/VS/DE,   |
// |            colour output, external-pixel/test-pattern mux and frame/line |
// |            start pulses. Optional macro VGA_TIMING_BORDER_EN forces a    |
// |            one-pixel all-ones border around the active area.            |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module vga_timing_gen #(
  parameter int COLOR_W  = 1,
  parameter int H_ACTIVE = 1920,
  parameter int H_FP     = 88,
  parameter int H_SYNC   = 44,
  parameter int H_BP     = 148,
  parameter int V_ACTIVE = 1080,
  parameter int V_FP     = 4,
  parameter int V_SYNC   = 5,
  parameter int V_BP     = 36,
  parameter int HS_POL   = 1,
  parameter int VS_POL   = 1
) (
  input wire               clk_i,
  input wire               rst_ni,
  vga_timing_gen_if.master bus
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int BAR_W   = H_ACTIVE / 8;
  localparam int BAR_H   = V_ACTIVE / 8;

  // Width-exact copies of the timing points so all compares are 12/11 bits.
  localparam logic [11:0] c_h_last     = 12'(H_TOTAL - 1);
  localparam logic [11:0] c_h_act      = 12'(H_ACTIVE);
  localparam logic [11:0] c_hs_beg     = 12'(H_ACTIVE + H_FP);
  localparam logic [11:0] c_hs_end     = 12'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [11:0] c_bar_w_last = 12'(BAR_W - 1);
  localparam logic [10:0] c_v_last     = 11'(V_TOTAL - 1);
  localparam logic [10:0] c_v_act      = 11'(V_ACTIVE);
  localparam logic [10:0] c_vs_beg     = 11'(V_ACTIVE + V_FP);
  localparam logic [10:0] c_vs_end     = 11'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [10:0] c_bar_h_last = 11'(BAR_H - 1);
  localparam logic        c_hs_on      = (HS_POL != 0);
  localparam logic        c_vs_on      = (VS_POL != 0);
`ifdef VGA_TIMING_BORDER_EN
  localparam logic [11:0] c_h_act_last = 12'(H_ACTIVE - 1);
  localparam logic [10:0] c_v_act_last = 11'(V_ACTIVE - 1);
`endif

  // Counters are fixed width; refuse configurations that would overflow them.
  if (H_TOTAL > 4096) begin : g_chk_h_total
    $error("vga_timing_gen: H_TOTAL exceeds 4096");
  end
  if (V_TOTAL > 2048) begin : g_chk_v_total
    $error("vga_timing_gen: V_TOTAL exceeds 2048");
  end
  if (H_ACTIVE < 8 || V_ACTIVE < 8) begin : g_chk_bars
    $error("vga_timing_gen: active area too small for 8 colour bars");
  end

  logic [11:0]        h_q, h_d, bxc_q, bxc_d;
  logic [10:0]        v_q, v_d, byc_q, byc_d;
  logic [2:0]         bx_q, bx_d, by_q, by_d;
  logic [1:0]         mode_q, mode_d;
  logic               hs_q, hs_d, vs_q, vs_d, de_q, de_d;
  logic               fs_q, fs_d, ls_q, ls_d;
  logic [COLOR_W-1:0] r_q, r_d, g_q, g_d, b_q, b_d;

  logic               w_h_wrap, w_v_wrap, w_active;
  logic [2:0]         w_code;

  assign w_h_wrap = (h_q == c_h_last);
  assign w_v_wrap = (v_q == c_v_last);
  assign w_active = (h_q < c_h_act) && (v_q < c_v_act);

  // Next-state: raster counters, bar sub-counters, mode latch and the output stage.
  always_comb begin
    h_d    = h_q + 12'd1;
    v_d    = v_q;
    bxc_d  = bxc_q + 12'd1;
    bx_d   = bx_q;
    byc_d  = byc_q;
    by_d   = by_q;
    mode_d = mode_q;
    w_code = 3'd0;
    r_d    = '0;
    g_d    = '0;
    b_d    = '0;

    if (w_h_wrap) begin
      h_d   = 12'd0;
      bxc_d = 12'd0;
      bx_d  = 3'd0;
      v_d   = w_v_wrap ? 11'd0 : v_q + 11'd1;
      if (w_v_wrap) begin
        byc_d = 11'd0;
        by_d  = 3'd0;
      end else if (byc_q == c_bar_h_last) begin
        byc_d = 11'd0;
        by_d  = (by_q == 3'd7) ? 3'd7 : by_q + 3'd1;
      end else begin
        byc_d = byc_q + 11'd1;
      end
    end else if (bxc_q == c_bar_w_last) begin
      bxc_d = 12'd0;
      bx_d  = (bx_q == 3'd7) ? 3'd7 : bx_q + 3'd1;
    end

    // Mode only changes on the very last blank pixel so frames are never mixed.
    if (w_h_wrap && w_v_wrap) begin
      mode_d = bus.mode_i;
    end

    case (mode_q)
      2'd1:    w_code = 3'd7 - bx_q;
      2'd2:    w_code = 3'd7 - by_q;
      default: w_code = (3'd7 - bx_q) ^ (3'd7 - by_q);
    endcase

    if (w_active) begin
      if (mode_q == 2'd0) begin
        r_d = bus.pix_r_i;
        g_d = bus.pix_g_i;
        b_d = bus.pix_b_i;
      end else begin
        r_d = {COLOR_W{w_code[2]}};
        g_d = {COLOR_W{w_code[1]}};
        b_d = {COLOR_W{w_code[0]}};
      end
`ifdef VGA_TIMING_BORDER_EN
      if (h_q == 12'd0 || h_q == c_h_act_last || v_q == 11'd0 || v_q == c_v_act_last) begin
        r_d = '1;
        g_d = '1;
        b_d = '1;
      end
`endif
    end

    hs_d = ((h_q >= c_hs_beg) && (h_q < c_hs_end)) ? c_hs_on : ~c_hs_on;
    vs_d = ((v_q >= c_vs_beg) && (v_q < c_vs_end)) ? c_vs_on : ~c_vs_on;
    de_d = w_active;
    fs_d = (h_q == 12'd0) && (v_q == 11'd0);
    ls_d = (h_q == 12'd0) && (v_q < c_v_act);
  end

  // State and output registers; async reset returns to the top-left, blanked, mode 0.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      h_q    <= 12'd0;
      v_q    <= 11'd0;
      bxc_q  <= 12'd0;
      bx_q   <= 3'd0;
      byc_q  <= 11'd0;
      by_q   <= 3'd0;
      mode_q <= 2'd0;
      hs_q   <= ~c_hs_on;
      vs_q   <= ~c_vs_on;
      de_q   <= 1'b0;
      fs_q   <= 1'b0;
      ls_q   <= 1'b0;
      r_q    <= '0;
      g_q    <= '0;
      b_q    <= '0;
    end else begin
      h_q    <= h_d;
      v_q    <= v_d;
      bxc_q  <= bxc_d;
      bx_q   <= bx_d;
      byc_q  <= byc_d;
      by_q   <= by_d;
      mode_q <= mode_d;
      hs_q   <= hs_d;
      vs_q   <= vs_d;
      de_q   <= de_d;
      fs_q   <= fs_d;
      ls_q   <= ls_d;
      r_q    <= r_d;
      g_q    <= g_d;
      b_q    <= b_d;
    end
  end

  assign bus.pix_x_o       = h_q;
  assign bus.pix_y_o       = v_q;
  assign bus.pix_act_o     = w_active;
  assign bus.vga_hs_o      = hs_q;
  assign bus.vga_vs_o      = vs_q;
  assign bus.vga_de_o      = de_q;
  assign bus.vga_r_o       = r_q;
  assign bus.vga_g_o       = g_q;
  assign bus.vga_b_o       = b_q;
  assign bus.frame_start_o = fs_q;
  assign bus.line_start_o  = ls_q;

endmodule
`default_nettype wire

// File: tb/tb_vga_timing_gen.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : tb_vga_timing_gen                                             |
// | Purpose  : Randomised self-checking bench for vga_timing_gen against an  |
// |            arithmetic raster model (reduced timing, 2-bit colour).       |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module tb_vga_timing_gen;

  localparam int CW     = 2;
  localparam int HA     = 42;
  localparam int HFP    = 4;
  localparam int HSY    = 6;
  localparam int HBP    = 8;
  localparam int VA     = 26;
  localparam int VFP    = 2;
  localparam int VSY    = 3;
  localparam int VBP    = 3;
  localparam int HS_POL = 1;
  localparam int VS_POL = 0;
  localparam int HT     = HA + HFP + HSY + HBP;
  localparam int VT     = VA + VFP + VSY + VBP;
  localparam int FRAME  = HT * VT;
  localparam int OW     = 3 * CW + 5;

  logic clk = 1'b0;
  logic rst_ni = 1'b0;
  int   n_cmp = 0;
  int   n_err = 0;
  int   t;
  int   m_mode;
  int   fidx;
  int   plan [5] = '{1, 2, 3, 0, 3};

  always #5 clk = ~clk;

  vga_timing_gen_if #(.COLOR_W(CW)) bus ();

  vga_timing_gen #(
    .COLOR_W(CW), .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HSY), .H_BP(HBP),
    .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VSY), .V_BP(VBP),
    .HS_POL(HS_POL), .VS_POL(VS_POL)
  ) u_dut (
    .clk_i (clk),
    .rst_ni(rst_ni),
    .bus   (bus)
  );

  // Count one comparison and report it if observed differs from expected.
  task automatic chk_value(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0d)", tag, obs, exp, t);
    end
  endtask

  function automatic logic [OW-1:0] dut_out();
    return {bus.vga_hs_o, bus.vga_vs_o, bus.vga_de_o, bus.vga_r_o, bus.vga_g_o,
            bus.vga_b_o, bus.frame_start_o, bus.line_start_o};
  endfunction

  // Expected registered outputs for raster position (h,v) in pattern mode m.
  function automatic logic [OW-1:0] model(input int h, input int v, input int m,
                                          input logic [CW-1:0] pr, input logic [CW-1:0] pg,
                                          input logic [CW-1:0] pb);
    logic act, in_hs, in_vs, hs, vs, fs, ls;
    int bx, by, code;
    logic [CW-1:0] r, g, b;
    act   = (h < HA) && (v < VA);
    in_hs = (h >= HA + HFP) && (h < HA + HFP + HSY);
    in_vs = (v >= VA + VFP) && (v < VA + VFP + VSY);
    hs    = (HS_POL != 0) ? in_hs : !in_hs;
    vs    = (VS_POL != 0) ? in_vs : !in_vs;
    bx    = h / (HA / 8);
    if (bx > 7) bx = 7;
    by    = v / (VA / 8);
    if (by > 7) by = 7;
    if (m == 1)      code = 7 - bx;
    else if (m == 2) code = 7 - by;
    else             code = (7 - bx) ^ (7 - by);
    r = '0; g = '0; b = '0;
    if (act) begin
      if (m == 0) begin
        r = pr; g = pg; b = pb;
      end else begin
        r = {CW{code[2]}}; g = {CW{code[1]}}; b = {CW{code[0]}};
      end
`ifdef VGA_TIMING_BORDER_EN
      if (h == 0 || h == HA - 1 || v == 0 || v == VA - 1) begin
        r = '1; g = '1; b = '1;
      end
`endif
    end
    fs = (h == 0) && (v == 0);
    ls = (h == 0) && (v < VA);
    return {hs, vs, act, r, g, b, fs, ls};
  endfunction

  function automatic logic [OW-1:0] reset_out();
    return {(HS_POL == 0), (VS_POL == 0), 1'b0, {3*CW{1'b0}}, 2'b00};
  endfunction

  // Run n cycles from a negedge: drive random inputs, check counters, then outputs.
  task automatic run_cycles(input int n);
    int h, v;
    logic [OW-1:0] exp;
    for (int i = 0; i < n; i++) begin
      h = t % HT;
      v = (t / HT) % VT;
      if (h == HT - 1 && v == VT - 1) bus.mode_i = 2'(plan[fidx % 5]);
      else                            bus.mode_i = 2'($urandom_range(0, 3));
      bus.pix_r_i = CW'($urandom);
      bus.pix_g_i = CW'($urandom);
      bus.pix_b_i = CW'($urandom);
      #1;
      chk_value("pix_xy", {8'd0, bus.pix_x_o, bus.pix_y_o, bus.pix_act_o},
                {8'd0, 12'(h), 11'(v), ((h < HA) && (v < VA))});
      exp = model(h, v, m_mode, bus.pix_r_i, bus.pix_g_i, bus.pix_b_i);
      if (h == HT - 1 && v == VT - 1) begin
        m_mode = int'(bus.mode_i);
        fidx++;
      end
      @(negedge clk);
      chk_value("vga_out", 32'(dut_out()), 32'(exp));
      t++;
    end
  endtask

  initial begin
    bus.mode_i  = 2'd0;
    bus.pix_r_i = '0;
    bus.pix_g_i = '0;
    bus.pix_b_i = '0;
    t = 0; m_mode = 0; fidx = 0;
    repeat (3) @(negedge clk);
    chk_value("rst_out", 32'(dut_out()), 32'(reset_out()));
    chk_value("rst_xy", {8'd0, bus.pix_x_o, bus.pix_y_o, bus.pix_act_o}, 32'd1);
    rst_ni = 1'b1;
    run_cycles(3 * FRAME + 17 * HT + 23);

    // Asynchronous reset mid-line: outputs must clear before the next edge.
    @(posedge clk);
    #2 rst_ni = 1'b0;
    #1;
    chk_value("arst_out", 32'(dut_out()), 32'(reset_out()));
    chk_value("arst_xy", {8'd0, bus.pix_x_o, bus.pix_y_o, bus.pix_act_o}, 32'd1);
    @(negedge clk);
    rst_ni = 1'b1;
    t = 0; m_mode = 0; fidx = 1;
    run_cycles(2 * FRAME + 50);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
